// File: rtl/mul_share_arbiter.sv
// Round-robin share of one ce-stalled pipelined multiplier among requesters.
// Optional perf counters enabled by defining MUL_ARB_PERF_EN.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int A_WIDTH     = 16,
  parameter int B_WIDTH     = 8,
  parameter int P_WIDTH     = 24,
  parameter int MUL_LATENCY = 3
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  logic [ID_W-1:0]        r_rr;
  logic [MUL_LATENCY-1:0] r_tv;
  logic [ID_W-1:0]        r_tid [MUL_LATENCY];

  logic            w_found;
  logic [ID_W-1:0] w_gid;
  logic            w_hs;

  assign rsp_valid = r_tv[MUL_LATENCY-1];
  assign rsp_id    = r_tid[MUL_LATENCY-1];
  assign rsp_p     = mul_dout;
  assign mul_ce    = !(rsp_valid && !rsp_ready);
  assign w_hs      = w_found && mul_ce;

  // Two-pass search: indices above rr first, then wrap; lowest index wins.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) > r_rr)) begin
        w_found = 1'b1;
        w_gid   = ID_W'(i);
      end
    end
    if (!w_found) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i] && (ID_W'(i) <= r_rr)) begin
          w_found = 1'b1;
          w_gid   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_gid == ID_W'(i))) begin
        req_ready[i] = mul_ce;
        mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
        mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr <= ID_W'(NUM_REQ - 1);
      r_tv <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) r_tid[i] <= '0;
    end else if (mul_ce) begin
      r_tv[0]  <= w_hs;
      r_tid[0] <= w_gid;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tid[i] <= r_tid[i-1];
      end
      if (w_hs) r_rr <= w_gid;
    end
  end

`ifdef MUL_ARB_PERF_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_hs && (r_issue_cnt != '1))
        r_issue_cnt <= r_issue_cnt + 32'd1;
      if (!mul_ce && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_issue_cnt = r_issue_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed table, corner sequences, random vs model.
// Perf counter checks run when MUL_ARB_PERF_EN is defined.
module tb_mul_share_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_p;
  logic        mul_ce;
  logic [15:0] mul_din0;
  logic [7:0]  mul_din1;
  logic [23:0] mul_dout;
`ifdef MUL_ARB_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [15:0] a_in [N];
  logic [7:0]  b_in [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = a_in[i];
      req_b[i*8 +: 8]   = b_in[i];
    end
  end

  // External multiplier model: 3 ce-enabled stages, no reset.
  logic [23:0] m_s [3];
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      m_s[0] <= mul_din0 * mul_din1;
      m_s[1] <= m_s[0];
      m_s[2] <= m_s[1];
    end
  end
  assign mul_dout = m_s[2];

  mul_share_arbiter dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_p    (rsp_p),
    .mul_ce   (mul_ce),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout)
`ifdef MUL_ARB_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: in-order list of issued products with age in pipeline edges.
  typedef struct {
    int          id;
    logic [23:0] p;
    int          age;
  } item_t;

  item_t q[$];
  int    m_rr;
  int    acc_ids[$];
  logic [23:0] acc_ps[$];
  logic [3:0]  obs_ready;

  function automatic int model_grant(input int rr, input logic [3:0] rv);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic        ev;
    logic        ece;
    int          g;
    logic [3:0]  erdy;
    logic [23:0] hp;
    @(negedge clk);
    ev   = (q.size() > 0) && (q[0].age == 3);
    ece  = !(ev && !rsp_ready);
    g    = model_grant(m_rr, req_valid);
    erdy = 4'd0;
    if (g >= 0 && ece) erdy[g] = 1'b1;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_p", 64'(rsp_p), 64'(q[0].p));
    end
    chk("mul_ce", 64'(mul_ce), 64'(ece));
    chk("req_ready", 64'(req_ready), 64'(erdy));
    chk("mul_din0", 64'(mul_din0), (g >= 0) ? 64'(a_in[g]) : 64'd0);
    chk("mul_din1", 64'(mul_din1), (g >= 0) ? 64'(b_in[g]) : 64'd0);
    obs_ready = req_ready;
    hp = 24'd0;
    if (g >= 0) hp = a_in[g] * b_in[g];
    @(posedge clk);
    if (ece) begin
      if (ev) begin
        acc_ids.push_back(q[0].id);
        acc_ps.push_back(q[0].p);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (g >= 0) begin
        q.push_back('{id: g, p: hp, age: 1});
        m_rr = g;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    m_rr = N - 1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_mul_ce", 64'(mul_ce), 64'd1);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          rid;
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] p;
  } vec_t;

  vec_t vt[8];
  logic [3:0] exp_oh[5];
  int   base;
  int   n;
`ifdef MUL_ARB_PERF_EN
  logic [31:0] snap_i;
  logic [31:0] snap_s;
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_in[i] = 16'(16'h1000 * (i + 1) + 16'h21);
      b_in[i] = 8'(8'h10 * (i + 1) + 8'h3);
    end
    q.delete();
    m_rr = N - 1;
    #2;
    do_reset();

    // All four held: grants rotate 0,1,2,3,0.
    exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    base = acc_ids.size();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_seq", 64'(obs_ready), 64'(exp_oh[k]));
    end
    req_valid = 4'd0;
    repeat (6) cycle();
    chk("rr_rsp_cnt", 64'(acc_ids.size() - base), 64'd5);
    for (int k = 0; k < 5 && base + k < acc_ids.size(); k++) begin
      chk("rr_rsp_id", 64'(acc_ids[base+k]), 64'(k % 4));
      chk("rr_rsp_p", 64'(acc_ps[base+k]),
          64'(a_in[k%4] * b_in[k%4]));
    end

    // Single-shot table: known products and fixed 3-cycle latency.
    vt[0] = '{0, 16'h1234, 8'h56, 24'h061D78};
    vt[1] = '{1, 16'hFFFF, 8'hFF, 24'hFEFF01};
    vt[2] = '{2, 16'h0000, 8'h12, 24'h000000};
    vt[3] = '{3, 16'h0001, 8'h01, 24'h000001};
    vt[4] = '{0, 16'h8000, 8'h02, 24'h010000};
    vt[5] = '{2, 16'hFFFF, 8'h01, 24'h00FFFF};
    vt[6] = '{1, 16'h0100, 8'h10, 24'h001000};
    vt[7] = '{3, 16'h00FF, 8'hFF, 24'h00FE01};
    for (int v = 0; v < 8; v++) begin
      a_in[vt[v].rid] = vt[v].a;
      b_in[vt[v].rid] = vt[v].b;
      req_valid = 4'd0;
      req_valid[vt[v].rid] = 1'b1;
      base = acc_ids.size();
      cycle();
      req_valid = 4'd0;
      n = 0;
      while (acc_ids.size() == base && n < 10) begin
        cycle();
        n++;
      end
      chk("tbl_latency", 64'(n), 64'd3);
      if (acc_ids.size() > base) begin
        chk("tbl_id", 64'(acc_ids[base]), 64'(vt[v].rid));
        chk("tbl_p", 64'(acc_ps[base]), 64'(vt[v].p));
      end
    end

    // Backpressure: stall 5 cycles once the first product is presented.
`ifdef MUL_ARB_PERF_EN
    snap_i = perf_issue_cnt;
    snap_s = perf_stall_cnt;
`endif
    base = acc_ids.size();
    req_valid = 4'hF;
    repeat (3) cycle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_ce", 64'(mul_ce), 64'd0);
      chk("bp_ready", 64'(obs_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    req_valid = 4'd0;
    repeat (6) cycle();
    chk("bp_rsp_cnt", 64'(acc_ids.size() - base), 64'd4);
`ifdef MUL_ARB_PERF_EN
    chk("perf_issue", 64'(perf_issue_cnt - snap_i), 64'd4);
    chk("perf_stall", 64'(perf_stall_cnt - snap_s), 64'd5);
`endif

    // Reset with three products in flight.
    req_valid = 4'b0110;
    repeat (3) cycle();
    req_valid = 4'd0;
    chk("pre_rst_inflight", 64'(q.size()), 64'd3);
    do_reset();
    base = acc_ids.size();
    repeat (6) cycle();
    chk("post_rst_stale", 64'(acc_ids.size() - base), 64'd0);
    req_valid = 4'hF;
    cycle();
    chk("post_rst_grant", 64'(obs_ready), 64'b0001);
    req_valid = 4'd0;

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        a_in[i] = 16'($urandom);
        b_in[i] = 8'($urandom);
      end
      cycle();
    end
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    repeat (8) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
